// File: rtl/joystick_pkg.sv
// rtl/joystick_pkg.sv - shared joystick field layout constants
package joystick_pkg;
  localparam int JOY_BITS  = 5;
  localparam int JOY_FIRE  = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_RIGHT = 2;
  localparam int JOY_DOWN  = 3;
  localparam int JOY_UP    = 4;
endpackage

// File: rtl/joy_debounce_bit.sv
// rtl/joy_debounce_bit.sv - synchroniser, optional inversion and debounce for one pin
module joy_debounce_bit #(
  parameter bit active_low      = 1'b1,
  parameter int debounce_cycles = 240
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic state,
  output logic changed
);
  localparam int CW = $clog2(debounce_cycles + 1);

  logic          sync1;
  logic          sync2;
  logic          value;
  logic [CW-1:0] cnt;

  // Flops reset to the raw idle level so the post-inversion value starts at 0.
  assign value = sync2 ^ active_low;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= active_low;
      sync2   <= active_low;
      state   <= 1'b0;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      changed <= 1'b0;
      if (value == state) begin
        cnt <= '0;
      end else if (cnt == CW'(debounce_cycles - 1)) begin
        state   <= value;
        cnt     <= '0;
        changed <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/joystick_conditioner.sv
// rtl/joystick_conditioner.sv - debounce, direction suppression, autofire and swap for N joystick ports
module joystick_conditioner
  import joystick_pkg::*;
#(
  parameter int num_ports       = 2,
  parameter int active_low      = 1,
  parameter int debounce_cycles = 240,
  parameter int autofire_half   = 250000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [JOY_BITS*num_ports-1:0] joy_raw,
  input  logic [num_ports-1:0]          autofire_en,
  input  logic                          swap,
  output logic [JOY_BITS*num_ports-1:0] joy_out,
  output logic                          activity
);
  localparam int NB = JOY_BITS * num_ports;
  localparam int AW = (autofire_half > 1) ? $clog2(autofire_half) : 1;

  logic [NB-1:0] deb;
  logic [NB-1:0] chg;
  logic [NB-1:0] cond;
  logic [NB-1:0] swapped;

  for (genvar b = 0; b < NB; b++) begin : g_bit
    joy_debounce_bit #(
      .active_low     (active_low != 0),
      .debounce_cycles(debounce_cycles)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (joy_raw[b]),
      .state  (deb[b]),
      .changed(chg[b])
    );
  end

  for (genvar p = 0; p < num_ports; p++) begin : g_port
    localparam int B = p * JOY_BITS;
    logic [AW-1:0] af_cnt;
    logic          af_phase;
    logic          af_active;
    logic          lr_both;
    logic          ud_both;

    assign af_active = autofire_en[p] & deb[B+JOY_FIRE];
    assign lr_both   = deb[B+JOY_LEFT] & deb[B+JOY_RIGHT];
    assign ud_both   = deb[B+JOY_UP] & deb[B+JOY_DOWN];

    // Held idle while inactive, so every (re)activation begins a fresh high half-period.
    always_ff @(posedge clk) begin
      if (reset || !af_active) begin
        af_cnt   <= '0;
        af_phase <= 1'b1;
      end else if (af_cnt == AW'(autofire_half - 1)) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + AW'(1);
      end
    end

    assign cond[B+JOY_FIRE]  = af_active ? af_phase : deb[B+JOY_FIRE];
    assign cond[B+JOY_LEFT]  = deb[B+JOY_LEFT] & ~lr_both;
    assign cond[B+JOY_RIGHT] = deb[B+JOY_RIGHT] & ~lr_both;
    assign cond[B+JOY_DOWN]  = deb[B+JOY_DOWN] & ~ud_both;
    assign cond[B+JOY_UP]    = deb[B+JOY_UP] & ~ud_both;
  end

  if (num_ports >= 2) begin : g_swap
    always_comb begin
      swapped = cond;
      if (swap) begin
        swapped[JOY_BITS-1:0]          = cond[2*JOY_BITS-1:JOY_BITS];
        swapped[2*JOY_BITS-1:JOY_BITS] = cond[JOY_BITS-1:0];
      end
    end
  end else begin : g_noswap
    assign swapped = cond;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      joy_out  <= '0;
      activity <= 1'b0;
    end else begin
      joy_out  <= swapped;
      activity <= |chg;
    end
  end
endmodule

// File: tb/tb_joystick_conditioner.sv
// tb/tb_joystick_conditioner.sv - scoreboard bench for joystick_conditioner (4 ports, debounce 4, autofire 3)
module tb_joystick_conditioner;
  localparam int NP = 4;
  localparam int NB = 5 * NP;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] joy_raw;
  logic [NP-1:0] autofire_en;
  logic          swap;
  logic [NB-1:0] joy_out;
  logic          activity;

  logic [NB-1:0] pressed;
  logic [NB-1:0] cur;
  logic [NB-1:0] base;
  logic [NB-1:0] mask;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  typedef struct {
    int            due;
    logic [NB-1:0] joy;
    logic          act;
    string         tag;
  } exp_t;
  exp_t q[$];

  assign joy_raw = ~pressed;

  joystick_conditioner #(
    .num_ports      (NP),
    .active_low     (1),
    .debounce_cycles(4),
    .autofire_half  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_raw    (joy_raw),
    .autofire_en(autofire_en),
    .swap       (swap),
    .joy_out    (joy_out),
    .activity   (activity)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] bm(input int n);
    logic [NB-1:0] one;
    one = 1;
    return one << n;
  endfunction

  task automatic chk(input int d, input logic [NB-1:0] j, input logic a, input string t);
    exp_t e;
    e.due = cyc + d;
    e.joy = j;
    e.act = a;
    e.tag = t;
    q.push_back(e);
  endtask

  // Outputs are sampled on the falling edge; stimulus is driven right after sampling.
  task automatic scan();
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        checks++;
        assert (joy_out === q[i].joy) else begin
          failures++;
          $error("FAIL %s joy_out observed=%h expected=%h cyc=%0d", q[i].tag, joy_out, q[i].joy, cyc);
        end
        checks++;
        assert (activity === q[i].act) else begin
          failures++;
          $error("FAIL %s activity observed=%b expected=%b cyc=%0d", q[i].tag, activity, q[i].act, cyc);
        end
        q.delete(i);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      scan();
    end
  endtask

  initial begin
    reset       = 1'b1;
    pressed     = '0;
    autofire_en = '0;
    swap        = 1'b0;
    cur         = '0;

    for (int d = 1; d <= 3; d++) chk(d, '0, 1'b0, "rst_hold");
    tick(3);
    reset = 1'b0;
    for (int d = 1; d <= 12; d++) chk(d, '0, 1'b0, "rst_idle");
    tick(14);

    // 3-cycle glitch on port 0 up must be filtered
    for (int d = 1; d <= 12; d++) chk(d, '0, 1'b0, "deb_glitch");
    pressed[4] = 1'b1;
    tick(3);
    pressed[4] = 1'b0;
    tick(3);
    pressed[4] = 1'b1;
    chk(6, '0, 1'b0, "deb_before");
    chk(7, bm(4), 1'b1, "deb_rise");
    chk(8, bm(4), 1'b0, "deb_pulse_end");
    tick(12);
    cur = bm(4);

    // port 1 left+right suppression
    pressed[6] = 1'b1;
    pressed[7] = 1'b1;
    chk(7, cur, 1'b1, "sup_both");
    chk(8, cur, 1'b0, "sup_both_hold");
    chk(12, cur, 1'b0, "sup_both_late");
    tick(12);
    pressed[7] = 1'b0;
    chk(6, cur, 1'b0, "sup_wait");
    chk(7, cur | bm(6), 1'b1, "sup_left");
    tick(10);
    pressed[6] = 1'b0;
    chk(7, cur, 1'b1, "sup_release");
    tick(10);

    // autofire on port 1, port 0 fire held without autofire
    autofire_en = 4'b0010;
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    base = cur | bm(0);
    for (int k = 0; k <= 8; k++)
      chk(7 + k, base | (((k % 6) < 3) ? bm(5) : '0), (k == 0), "af_pattern");
    tick(9);
    pressed[5] = 1'b0;
    for (int k = 7; k <= 12; k++) chk(k, base, (k == 7), "af_release");
    tick(13);

    // enabling mid-press starts high; disabling restores steady fire next cycle
    autofire_en = 4'b0011;
    chk(1, base, 1'b0, "af_en_p1");
    chk(2, base, 1'b0, "af_en_p2");
    chk(3, base, 1'b0, "af_en_p3");
    chk(4, cur, 1'b0, "af_en_low");
    tick(4);
    autofire_en = 4'b0000;
    chk(1, base, 1'b0, "af_disable");
    chk(2, base, 1'b0, "af_disable_hold");
    tick(3);
    pressed[0] = 1'b0;
    chk(7, cur, 1'b1, "af_fire_release");
    tick(10);

    // swap: port 0 fire, port 1 up, port 2 down stays in place
    pressed[4]  = 1'b0;
    pressed[0]  = 1'b1;
    pressed[9]  = 1'b1;
    pressed[13] = 1'b1;
    cur = bm(0) | bm(9) | bm(13);
    chk(7, cur, 1'b1, "swap_setup");
    tick(10);
    swap = 1'b1;
    chk(1, bm(4) | bm(5) | bm(13), 1'b0, "swap_on");
    chk(3, bm(4) | bm(5) | bm(13), 1'b0, "swap_hold");
    tick(4);
    swap = 1'b0;
    chk(1, cur, 1'b0, "swap_off");
    tick(3);

    // simultaneous changes across all four ports
    pressed = '0;
    chk(6, cur, 1'b0, "sim_rel_before");
    chk(7, '0, 1'b1, "sim_rel");
    chk(8, '0, 1'b0, "sim_rel_single");
    tick(10);
    mask = bm(1) | bm(8) | bm(12) | bm(19);
    pressed = mask;
    chk(6, '0, 1'b0, "sim_before");
    chk(7, mask, 1'b1, "sim_all");
    chk(8, mask, 1'b0, "sim_single");
    tick(10);

    // reset mid-debounce discards progress; held inputs re-accepted after full latency
    pressed[15] = 1'b1;
    tick(3);
    reset = 1'b1;
    chk(1, '0, 1'b0, "rst_mid");
    tick(1);
    reset = 1'b0;
    chk(1, '0, 1'b0, "rst_relatch_0");
    chk(6, '0, 1'b0, "rst_relatch_wait");
    chk(7, mask | bm(15), 1'b1, "rst_relatch");
    chk(8, mask | bm(15), 1'b0, "rst_relatch_hold");
    tick(10);

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
